// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg
// Purpose : Shared types and default sizing for the store buffer and its
//           forwarding search.
// Contents: SB_DEPTH / SB_AW / SB_DW defaults, SB_PTR_W pointer width,
//           sb_entry_t {valid, adr, data} entry payload.
// ---------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;
    localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);

    // One buffered store
    typedef struct packed {
        logic              valid;
        logic [SB_AW-1:0]  adr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

endpackage : store_buffer_pkg

// File: rtl/sb_fwd_match.sv
// ---------------------------------------------------------------------------
// sb_fwd_match
// Purpose : Combinational load-forwarding search over the buffer entries.
//           The youngest valid entry (tail-1, then tail-2, ...) whose address
//           matches the load address wins.
// Ports   : i_ld_req  - load in progress (gates the hit)
//           i_ld_adr  - load address
//           i_valid   - per-entry valid bits
//           i_adr     - per-entry addresses
//           i_data    - per-entry data
//           i_tail    - allocation pointer (next free slot)
//           o_hit     - some valid entry matches
//           o_data    - data of the youngest matching entry (0 if no hit)
// ---------------------------------------------------------------------------
module sb_fwd_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                      i_ld_req,
    input  logic [AW-1:0]             i_ld_adr,
    input  logic [DEPTH-1:0]          i_valid,
    input  logic [DEPTH-1:0][AW-1:0]  i_adr,
    input  logic [DEPTH-1:0][DW-1:0]  i_data,
    input  logic [PTR_W-1:0]          i_tail,
    output logic                      o_hit,
    output logic [DW-1:0]             o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest (tail-DEPTH) to youngest (tail-1); a later match overrides,
    // so the youngest matching entry has priority.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = int'(DEPTH); i >= 1; i--) begin
            w_idx = PTR_W'(i_tail - PTR_W'(i));
            if (i_ld_req && i_valid[w_idx] && (i_adr[w_idx] == i_ld_adr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule : sb_fwd_match

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Purpose : FIFO store buffer between the core data-memory write port and
//           data memory. One store accepted and one drained per cycle,
//           stall when full, forwarding of buffered data to matching loads.
// Ports   : clk, reset (async, active-low)
//           MemWrite/DataAdr/WriteData - core store request (DataAdr is also
//                                        the load address when ld_req=1)
//           StoreStall                 - store not accepted this cycle (comb)
//           mem_we/mem_adr/mem_wd      - head entry toward memory
//           mem_ready                  - memory takes head entry this cycle
//           ld_req                     - core load in progress
//           fwd_hit/fwd_data           - load forwarding result (comb)
//           count                      - occupancy
// Config  : STORE_COALESCE_EN - when defined, a store to the same address as
//           the youngest entry overwrites that entry's data.
// ---------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    output logic                     StoreStall,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wd,
    input  logic                     mem_ready,
    input  logic                     ld_req,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]          r_valid;
    logic [DEPTH-1:0][AW-1:0]  r_adr;
    logic [DEPTH-1:0][DW-1:0]  r_data;
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_coal;
    logic w_alloc;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = mem_we & mem_ready;

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] w_last;

    // Youngest entry; never coalesce into a head that leaves this cycle
    assign w_last = PTR_W'(r_tail - PTR_W'(1));
    assign w_coal = MemWrite & ~w_empty & (r_adr[w_last] == DataAdr)
                  & ~((r_count == CNT_W'(1)) & w_pop);
`else
    assign w_coal = 1'b0;
`endif

    // A pop frees a slot in the same cycle, so push is legal even when full
    assign w_push     = MemWrite & (~w_full | w_pop | w_coal);
    assign w_alloc    = w_push & ~w_coal;
    assign StoreStall = MemWrite & w_full & ~w_pop & ~w_coal;

    // Drain side reads the head entry directly; held while memory back-pressures
    assign mem_we  = ~w_empty;
    assign mem_adr = r_adr[r_head];
    assign mem_wd  = r_data[r_head];
    assign count   = r_count;

    // Entry storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_adr   <= '0;
            r_data  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= PTR_W'(r_head + PTR_W'(1));
            end
            // Allocation after pop: when full, tail == head and the new entry wins
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_adr[r_tail]   <= DataAdr;
                r_data[r_tail]  <= WriteData;
                r_tail          <= PTR_W'(r_tail + PTR_W'(1));
            end
`ifdef STORE_COALESCE_EN
            else if (w_coal) begin
                r_data[w_last] <= WriteData;
            end
`endif
            case ({w_alloc, w_pop})
                2'b10:   r_count <= CNT_W'(r_count + CNT_W'(1));
                2'b01:   r_count <= CNT_W'(r_count - CNT_W'(1));
                default: r_count <= r_count;
            endcase
        end
    end

    // Load forwarding search
    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PTR_W (PTR_W)
    ) u_fwd (
        .i_ld_req (ld_req),
        .i_ld_adr (DataAdr),
        .i_valid  (r_valid),
        .i_adr    (r_adr),
        .i_data   (r_data),
        .i_tail   (r_tail),
        .o_hit    (fwd_hit),
        .o_data   (fwd_data)
    );

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
// Self-checking bench for store_buffer. A queue-based model of the buffer
// predicts every output; directed scenarios plus randomized traffic.
// ---------------------------------------------------------------------------
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int unsigned DEPTH = SB_DEPTH;
    localparam int unsigned AW    = SB_AW;
    localparam int unsigned DW    = SB_DW;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;
    logic          StoreStall;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic          mem_ready;
    logic          ld_req;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .StoreStall (StoreStall),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wd     (mem_wd),
        .mem_ready  (mem_ready),
        .ld_req     (ld_req),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue front = oldest store
    sb_entry_t q[$];
    sb_entry_t act_log[$];
    sb_entry_t exp_log[$];

    logic          obs_we, obs_stall, obs_hit;
    logic [AW-1:0] obs_adr;
    logic [DW-1:0] obs_wd, obs_fwd;
    logic [CW-1:0] obs_count;

    logic          exp_we, exp_stall, exp_hit;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_wd, exp_fwd;
    logic [CW-1:0] exp_count;
    bit            m_pop, m_push, m_coal;
    int            max_count;

    function automatic void calc_exp();
        int n = q.size();
        exp_count = CW'(n);
        exp_we    = (n > 0);
        exp_adr   = (n > 0) ? q[0].adr  : '0;
        exp_wd    = (n > 0) ? q[0].data : '0;
        m_pop     = (n > 0) && mem_ready;
        m_coal    = 1'b0;
`ifdef STORE_COALESCE_EN
        if (MemWrite && n > 0 && q[n-1].adr == DataAdr && !(n == 1 && m_pop))
            m_coal = 1'b1;
`endif
        m_push    = MemWrite && ((n < int'(DEPTH)) || m_pop || m_coal);
        exp_stall = MemWrite && !m_push;
        exp_hit   = 1'b0;
        exp_fwd   = '0;
        if (ld_req) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (q[i].adr == DataAdr) begin
                    exp_hit = 1'b1;
                    exp_fwd = q[i].data;
                    break;
                end
            end
        end
    endfunction

    function automatic void commit();
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
            if (m_coal) q[q.size()-1].data = WriteData;
            else        q.push_back('{valid: 1'b1, adr: DataAdr, data: WriteData});
        end
    endfunction

    // One clock: drive, sample mid-cycle, predict, advance model and clock
    task automatic step(input logic mw, input logic [AW-1:0] adr,
                        input logic [DW-1:0] wd, input logic rdy, input logic ld);
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        mem_ready = rdy;
        ld_req    = ld;
        #3;
        obs_we    = mem_we;
        obs_adr   = mem_adr;
        obs_wd    = mem_wd;
        obs_stall = StoreStall;
        obs_hit   = fwd_hit;
        obs_fwd   = fwd_data;
        obs_count = count;
        calc_exp();
        if (obs_we === 1'b1 && rdy)
            act_log.push_back('{valid: 1'b1, adr: obs_adr, data: obs_wd});
        if (int'(obs_count) > max_count) max_count = int'(obs_count);
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20; n++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            if (obs_we !== 1'b1) break;
        end
        checks++;
        if (obs_we !== 1'b0 || obs_count !== '0) begin
            errors++;
            $display("FAIL %s_drain: mem_we=%b count=%0d, need 0/0", name, obs_we, obs_count);
        end
    endtask

    task automatic check_log(input string name);
        checks++;
        if (act_log.size() != exp_log.size()) begin
            errors++;
            $display("FAIL %s_log_len: got %0d writes, need %0d", name, act_log.size(), exp_log.size());
        end else begin
            foreach (exp_log[i]) begin
                checks++;
                if (act_log[i].adr !== exp_log[i].adr || act_log[i].data !== exp_log[i].data) begin
                    errors++;
                    $display("FAIL %s_write%0d: got %0h:%0h, need %0h:%0h", name, i,
                             act_log[i].adr, act_log[i].data, exp_log[i].adr, exp_log[i].data);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        mem_ready = 1'b0; ld_req = 1'b1;
        #12;
        checks++;
        if (count !== '0 || mem_we !== 1'b0 || StoreStall !== 1'b0 || fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: count=%0d we=%b stall=%b hit=%b, need all 0",
                     count, mem_we, StoreStall, fwd_hit);
        end
        checks++;
        if (mem_adr !== '0 || mem_wd !== '0 || fwd_data !== '0) begin
            errors++;
            $display("FAIL reset_data: adr=%h wd=%h fwd=%h, need 0", mem_adr, mem_wd, fwd_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
    endtask

    task automatic test_single_store();
        act_log.delete();
        step(1'b1, AW'(100), DW'(25), 1'b1, 1'b0);
        checks++;
        if (obs_we !== 1'b0) begin
            errors++;
            $display("FAIL single_bypass: mem_we=%b in accept cycle, need 0", obs_we);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_we !== 1'b1 || obs_adr !== AW'(100) || obs_wd !== DW'(25) || obs_count !== CW'(1)) begin
            errors++;
            $display("FAIL single_out: we=%b adr=%0d wd=%0d cnt=%0d, need 1/100/25/1",
                     obs_we, obs_adr, obs_wd, obs_count);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_we !== 1'b0 || obs_count !== '0) begin
            errors++;
            $display("FAIL single_empty: we=%b cnt=%0d, need 0/0", obs_we, obs_count);
        end
    endtask

    task automatic test_fill_stall();
        act_log.delete();
        exp_log.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, AW'(96 + 4 * i), DW'(i + 1), 1'b0, 1'b0);
            exp_log.push_back('{valid: 1'b1, adr: AW'(96 + 4 * i), data: DW'(i + 1)});
        end
        step(1'b1, AW'(112), DW'(55), 1'b0, 1'b0);
        checks++;
        if (obs_count !== CW'(4) || obs_stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_stall: cnt=%0d stall=%b, need 4/1", obs_count, obs_stall);
        end
        step(1'b1, AW'(112), DW'(55), 1'b1, 1'b0);
        checks++;
        if (obs_stall !== 1'b0 || obs_count !== CW'(4)) begin
            errors++;
            $display("FAIL fill_pushpop: stall=%b cnt=%0d, need 0/4", obs_stall, obs_count);
        end
        exp_log.push_back('{valid: 1'b1, adr: AW'(112), data: DW'(55)});
        drain("fill");
        check_log("fill");
    endtask

    task automatic test_forward();
        step(1'b1, AW'(100), DW'(7), 1'b0, 1'b0);
        step(1'b1, AW'(100), DW'(25), 1'b0, 1'b0);
        step(1'b0, AW'(100), '0, 1'b0, 1'b1);
        checks++;
        if (obs_hit !== 1'b1 || obs_fwd !== DW'(25)) begin
            errors++;
            $display("FAIL fwd_hit: hit=%b data=%0d, need 1/25", obs_hit, obs_fwd);
        end
        step(1'b0, AW'(200), '0, 1'b0, 1'b1);
        checks++;
        if (obs_hit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_miss: hit=%b, need 0", obs_hit);
        end
        step(1'b0, AW'(100), '0, 1'b0, 1'b0);
        checks++;
        if (obs_hit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_noreq: hit=%b, need 0", obs_hit);
        end
        // Head pops this cycle and must still count as a hit
        step(1'b0, AW'(100), '0, 1'b1, 1'b1);
        checks++;
        if (obs_hit !== 1'b1 || obs_fwd !== DW'(25)) begin
            errors++;
            $display("FAIL fwd_popping: hit=%b data=%0d, need 1/25", obs_hit, obs_fwd);
        end
        drain("fwd");
    endtask

    task automatic test_wrap();
        act_log.delete();
        exp_log.delete();
        max_count = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, AW'(32'h200 + 4 * i), DW'(1000 + i), ((i / 2) % 2) == 1, 1'b0);
                exp_log.push_back('{valid: 1'b1, adr: AW'(32'h200 + 4 * i), data: DW'(1000 + i)});
            end else begin
                step(1'b0, '0, '0, ((i / 2) % 2) == 1, 1'b0);
            end
        end
        drain("wrap");
        check_log("wrap");
        checks++;
        if (max_count > 4) begin
            errors++;
            $display("FAIL wrap_maxcount: got %0d, need <= 4", max_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) step(1'b1, AW'(32'h300 + 4 * i), DW'(i + 9), 1'b0, 1'b0);
        MemWrite = 1'b0;
        mem_ready = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL rst_mid: we=%b cnt=%0d, need 0/0", mem_we, count);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        act_log.delete();
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (act_log.size() != 0 || obs_count !== '0) begin
            errors++;
            $display("FAIL rst_stale: writes=%0d cnt=%0d, need 0/0", act_log.size(), obs_count);
        end
    endtask

    task automatic test_coalesce();
        act_log.delete();
        exp_log.delete();
        step(1'b1, AW'(96), DW'(1), 1'b0, 1'b0);
        step(1'b1, AW'(96), DW'(2), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
`ifdef STORE_COALESCE_EN
        if (obs_count !== CW'(1)) begin
            errors++;
            $display("FAIL coal_count: got %0d, need 1", obs_count);
        end
        exp_log.push_back('{valid: 1'b1, adr: AW'(96), data: DW'(2)});
`else
        if (obs_count !== CW'(2)) begin
            errors++;
            $display("FAIL coal_count: got %0d, need 2", obs_count);
        end
        exp_log.push_back('{valid: 1'b1, adr: AW'(96), data: DW'(1)});
        exp_log.push_back('{valid: 1'b1, adr: AW'(96), data: DW'(2)});
`endif
        drain("coal");
        check_log("coal");
    endtask

    task automatic test_random();
        logic          mw, rdy, ld;
        logic [AW-1:0] adr;
        int            phase;
        for (int k = 0; k < 400; k++) begin
            phase = (k / 40) % 4;
            mw  = ($urandom_range(0, 2) != 0);
            adr = AW'(32'h40 + 4 * $urandom_range(0, 3));
            rdy = ($urandom_range(0, 3) < phase);
            ld  = $urandom_range(0, 1) == 1;
            step(mw, adr, DW'($urandom), rdy, ld);
            checks++;
            if (obs_we !== exp_we || obs_stall !== exp_stall || obs_hit !== exp_hit ||
                obs_count !== exp_count ||
                (exp_we && (obs_adr !== exp_adr || obs_wd !== exp_wd)) ||
                (exp_hit && obs_fwd !== exp_fwd)) begin
                errors++;
                $display("FAIL random_cyc%0d: got we=%b adr=%h wd=%h stall=%b hit=%b fwd=%h cnt=%0d need we=%b adr=%h wd=%h stall=%b hit=%b fwd=%h cnt=%0d",
                         k, obs_we, obs_adr, obs_wd, obs_stall, obs_hit, obs_fwd, obs_count,
                         exp_we, exp_adr, exp_wd, exp_stall, exp_hit, exp_fwd, exp_count);
            end
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill_stall();
        test_forward();
        test_wrap();
        test_reset_mid_drain();
        test_coalesce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule : tb_store_buffer

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO store buffer between the core's data-memory write port (MemWrite/DataAdr/WriteData) and data memory.
- Accepts one store per cycle from the core and drains one store per cycle to memory under a valid/ready handshake.
- Gives the core a stall signal when full, and forwards buffered data to loads that hit a pending store.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; state clears while reset==0.
- MemWrite  in  1  core store request.
- DataAdr  in  AW  core store/load address.
- WriteData  in  DW  core store data.
- StoreStall  out  1  store not accepted this cycle; core holds the request.
- mem_we  out  1  head entry valid toward memory.
- mem_adr  out  AW  head entry address.
- mem_wd  out  DW  head entry data.
- mem_ready  in  1  memory accepts head entry this cycle.
- ld_req  in  1  core load in progress; DataAdr is the load address.
- fwd_hit  out  1  load address matches a buffered entry.
- fwd_data  out  DW  data of the youngest matching entry.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: count=0, head/tail pointers=0, all entry valid bits=0, mem_we=0, StoreStall=0, fwd_hit=0. Outputs mem_adr, mem_wd and fwd_data are don't-care while their qualifiers are 0, but are driven to 0 during reset.
- State: DEPTH entries of {valid, adr, data}; head ptr, tail ptr, count.
- Occupancy flags: full is count==DEPTH; empty is count==0.
- pop = mem_we & mem_ready.
- push = MemWrite & (!full | pop). Push and pop in the same cycle are legal at every occupancy, including full.
- StoreStall = MemWrite & full & !pop. This is combinational.
- Latency: a store accepted at edge N appears on mem_we/mem_adr/mem_wd after edge N. There is no empty-bypass; minimum latency to memory is 1 cycle.
- Drain outputs:
  - mem_we = !empty.
  - mem_adr and mem_wd come from the head entry.
  - While mem_we=1 && !mem_ready, mem_adr and mem_wd are held stable.
- Pointers: both wrap modulo DEPTH. count increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Ordering: strict FIFO; memory sees stores in acceptance order.
- Forwarding (combinational):
  - fwd_hit = ld_req & (some valid entry has adr==DataAdr).
  - fwd_data comes from the youngest such entry.
  - An entry popping this cycle still counts as a hit.
  - A same-cycle incoming store is not forwarded.
- Simultaneous MemWrite and ld_req is not legal from the core. If it occurs anyway, forwarding uses DataAdr as the load address.
- Reset mid-drain: every pending entry is discarded and nothing further is presented to memory.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- When defined, a push whose DataAdr equals the youngest valid entry's adr overwrites that entry's data instead of allocating a new entry; count is unchanged.
  - Coalescing is suppressed when that entry is the head and pop is asserted this cycle; the store allocates normally.
  - Coalescing is allowed when full. The store is accepted and StoreStall=0 for that request.
- When undefined, every push allocates an entry.

Decomposition:
- Shared package holds:
  - the entry typedef {valid, adr, data};
  - the DEPTH default;
  - the pointer-width constant $clog2(DEPTH).
- One sub-module, sb_fwd_match: a priority search that is youngest-first from tail-1 and returns hit and data. It is purely combinational and instantiated once.

Test Plan:
- Single store: MemWrite=1, DataAdr=100, WriteData=25 for one cycle, mem_ready=1. Expect mem_we=1, mem_adr=100, mem_wd=25 exactly one cycle later; count returns to 0 the cycle after that.
- Fill and stall: mem_ready=0, push 4 stores to 96, 100, 104, 108.
  - Expect count=4 and StoreStall=1 on the 5th request.
  - Raise mem_ready: the 5th store is accepted in the same cycle; drain order is 96, 100, 104, 108, then the 5th.
- Forwarding: buffer holds {100:7, 100:25} with mem_ready=0. Load with ld_req=1, DataAdr=100 gives fwd_hit=1, fwd_data=25. Load with DataAdr=200 gives fwd_hit=0.
- Wrap-around: alternate push/pop for 10 stores with mem_ready toggling every other cycle. Memory receives all 10 in order; count never exceeds 4.
- Reset mid-drain: 3 entries pending, reset=0 asynchronously mid-cycle. mem_we and count drop to 0 immediately; after release no stale store appears.
- STORE_COALESCE_EN: with mem_ready=0, push 96:1 then 96:2. Expect count=1, and after raising mem_ready, exactly one write 96:2. Without the macro: count=2 and writes 96:1 then 96:2.
